store_queue: RTL and testbench

- Store queue directly upstream of the unified memory's data write port (`dw_en`/`dw_addr`/`dw_data`/`dw_len`).
- Accepts stores from the LSU over a valid/ready handshake and validates them: length, alignment, address range.
- Buffers up to DEPTH stores in program order and drains one per cycle into the memory write port.
- Flags loads that overlap a pending store so the LSU stalls them, because memory reads are combinational and bypass the queue.

---
 rtl/store_queue_pkg.sv | 35 +++
 rtl/store_queue_fifo.sv | 55 +++++
 rtl/store_queue.sv | 121 ++++++++++++
 tb/tb_store_queue.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_queue_pkg.sv
// Shared types and helpers for the store queue: entry layout, store lengths,
// byte-lane masks and length legality.
package store_queue_pkg;

    localparam int SQ_ADDR_W = 32;
    localparam int SQ_DATA_W = 32;

    localparam logic [SQ_DATA_W-1:0] LEN_B = 1;
    localparam logic [SQ_DATA_W-1:0] LEN_H = 2;
    localparam logic [SQ_DATA_W-1:0] LEN_W = 4;

    typedef struct packed {
        logic [SQ_ADDR_W-1:0] addr;
        logic [SQ_DATA_W-1:0] data;
        logic [SQ_DATA_W-1:0] len;
    } sq_entry_t;

    // Lanes beyond the word are dropped; an unknown length covers the whole word.
    function automatic logic [3:0] byte_mask(input logic [1:0] lane,
                                             input logic [SQ_DATA_W-1:0] len);
        logic [3:0] mask;
        case (len)
            LEN_B:   mask = 4'b0001 << lane;
            LEN_H:   mask = 4'b0011 << lane;
            LEN_W:   mask = 4'b1111 << lane;
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

    function automatic logic len_legal(input logic [SQ_DATA_W-1:0] len);
        return (len == LEN_B) || (len == LEN_H) || (len == LEN_W);
    endfunction

endpackage

// File: rtl/store_queue_fifo.sv
// Circular FIFO of store entries; exposes the raw entry array and a per-slot
// valid vector so the owner can scan pending stores.
module store_queue_fifo
    import store_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  sq_entry_t                    wr_entry,
    input  logic                         pop,
    output sq_entry_t                    head,
    output logic [$clog2(DEPTH):0]       count,
    output sq_entry_t                    entries [DEPTH],
    output logic [DEPTH-1:0]             valid
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [DEPTH-1:0] valid_d;
    sq_entry_t        mem [DEPTH];

    always_comb begin
        valid_d = valid;
        if (pop)  valid_d[rd_ptr] = 1'b0;
        if (push) valid_d[wr_ptr] = 1'b1;
    end

    // Pointers are exactly log2(DEPTH) bits wide, so they wrap on their own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            valid <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_entry;
    end

    assign head    = mem[rd_ptr];
    assign entries = mem;

endmodule

// File: rtl/store_queue.sv
// Store queue in front of the memory write port: validates LSU stores, drains
// one per cycle, and flags loads that overlap a pending store.
module store_queue
    import store_queue_pkg::*;
#(
    parameter int                    DEPTH       = 4,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] ORIGIN_ADDR = 32'h80000000,
    parameter logic [ADDR_WIDTH-1:0] MEM_SIZE    = 32'h08000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  st_valid,
    output logic                  st_ready,
    input  logic [ADDR_WIDTH-1:0] st_addr,
    input  logic [DATA_WIDTH-1:0] st_data,
    input  logic [DATA_WIDTH-1:0] st_len,
    output logic                  dw_en,
    output logic [ADDR_WIDTH-1:0] dw_addr,
    output logic [DATA_WIDTH-1:0] dw_data,
    output logic [DATA_WIDTH-1:0] dw_len,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_len,
    output logic                  ld_conflict,
    input  logic                  fence_req,
    output logic                  fence_done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] err_addr,
    input  logic                  err_clr
);

    localparam int                  CW     = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]       FULL   = CW'(DEPTH);
    localparam logic [ADDR_WIDTH:0] WIN_LO = {1'b0, ORIGIN_ADDR};
    localparam logic [ADDR_WIDTH:0] WIN_HI = {1'b0, ORIGIN_ADDR} + {1'b0, MEM_SIZE};

    logic [CW-1:0]       count;
    sq_entry_t           head;
    sq_entry_t           wr_entry;
    sq_entry_t           entries [DEPTH];
    logic [DEPTH-1:0]    valid;
    logic                accept, aligned, in_range, st_legal, push, reject, pop;
    logic [ADDR_WIDTH:0] st_end;
    logic [3:0]          ld_mask;

    // Handshake: a store transfers on a clk edge where st_valid && st_ready;
    // st_ready depends only on registered state and fence_req, never on st_valid,
    // and a rejected store still completes its handshake.
    assign st_ready = !rst && (count != FULL) && !fence_req;
    assign accept   = st_valid && st_ready;

    always_comb begin
        aligned = 1'b1;
        case (st_len)
            LEN_H:   aligned = !st_addr[0];
            LEN_W:   aligned = (st_addr[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
    end

    // One extra bit so a window end computed past the top of the address space
    // is seen as out of range rather than wrapping.
    assign st_end   = {1'b0, st_addr} + (ADDR_WIDTH + 1)'(st_len);
    assign in_range = ({1'b0, st_addr} >= WIN_LO) && (st_end <= WIN_HI);
    assign st_legal = len_legal(st_len) && aligned && in_range;

    assign push   = accept && st_legal;
    assign reject = accept && !st_legal;
    assign pop    = (count != '0);

    always_comb begin
        wr_entry      = '0;
        wr_entry.addr = st_addr;
        wr_entry.data = st_data;
        wr_entry.len  = st_len;
    end

    store_queue_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .wr_entry (wr_entry),
        .pop      (pop),
        .head     (head),
        .count    (count),
        .entries  (entries),
        .valid    (valid)
    );

    assign dw_en   = pop;
    assign dw_addr = pop ? head.addr : '0;
    assign dw_data = pop ? head.data : '0;
    assign dw_len  = pop ? head.len  : '0;

    assign fence_done = !rst && fence_req && (count == '0);

    // The slot draining this cycle is still valid here, so it keeps stalling loads.
    always_comb begin
        ld_mask     = byte_mask(ld_addr[1:0], ld_len);
        ld_conflict = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (entries[i].addr[ADDR_WIDTH-1:2] == ld_addr[ADDR_WIDTH-1:2]) &&
                ((byte_mask(entries[i].addr[1:0], entries[i].len) & ld_mask) != 4'b0000))
                ld_conflict = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err      <= 1'b0;
            err_addr <= '0;
        end else if (reject) begin
            err <= 1'b1;
            if (!err || err_clr) err_addr <= st_addr;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_store_queue.sv
// Bench for store_queue: directed scenarios plus randomized traffic, all checked
// against a byte-level reference model of the queue contents and error state.
module tb_store_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        st_valid = 1'b0;
    logic        st_ready;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic [31:0] st_len  = '0;
    logic        dw_en;
    logic [31:0] dw_addr, dw_data, dw_len;
    logic [31:0] ld_addr = '0;
    logic [31:0] ld_len  = '0;
    logic        ld_conflict;
    logic        fence_req = 1'b0;
    logic        fence_done;
    logic        err;
    logic [31:0] err_addr;
    logic        err_clr = 1'b0;

    int checks   = 0;
    int failures = 0;
    int writes_seen = 0;

    logic [95:0] exp_q[$];      // {addr, data, len} of stores still pending
    bit          err_m = 1'b0;
    logic [31:0] err_addr_m = '0;
    bit          pop_pending = 1'b0;

    store_queue dut (
        .clk         (clk),
        .rst         (rst),
        .st_valid    (st_valid),
        .st_ready    (st_ready),
        .st_addr     (st_addr),
        .st_data     (st_data),
        .st_len      (st_len),
        .dw_en       (dw_en),
        .dw_addr     (dw_addr),
        .dw_data     (dw_data),
        .dw_len      (dw_len),
        .ld_addr     (ld_addr),
        .ld_len      (ld_len),
        .ld_conflict (ld_conflict),
        .fence_req   (fence_req),
        .fence_done  (fence_done),
        .err         (err),
        .err_addr    (err_addr),
        .err_clr     (err_clr)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic bit legal_m(input logic [31:0] a, input logic [31:0] l);
        longint unsigned lo, hi;
        if (!(l == 1 || l == 2 || l == 4)) return 1'b0;
        if ((a % l) != 0) return 1'b0;
        lo = longint'(a);
        hi = longint'(a) + longint'(l);
        return (lo >= 64'h8000_0000) && (hi <= 64'h8800_0000);
    endfunction

    // Byte-address overlap, confined to the load's own word.
    function automatic bit conflict_m(input logic [31:0] la, input logic [31:0] ll);
        logic [31:0] sa, sl, sbyte, lbyte;
        foreach (exp_q[k]) begin
            sa = exp_q[k][95:64];
            sl = exp_q[k][31:0];
            for (int sb = 0; sb < int'(sl); sb++) begin
                sbyte = sa + sb;
                if (ll == 1 || ll == 2 || ll == 4) begin
                    for (int lb = 0; lb < int'(ll); lb++) begin
                        lbyte = la + lb;
                        if (lbyte[31:2] == la[31:2] && lbyte == sbyte) return 1'b1;
                    end
                end else if (sbyte[31:2] == la[31:2]) begin
                    return 1'b1;
                end
            end
        end
        return 1'b0;
    endfunction

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        #1;
        if (!rst) begin
            checks++;
            if (dw_en !== (exp_q.size() != 0)) begin
                failures++;
                $display("FAIL mon_dw_en got=%0b exp=%0b t=%0t", dw_en, exp_q.size() != 0, $time);
            end
            if (exp_q.size() != 0) begin
                checks++;
                if ({dw_addr, dw_data, dw_len} !== exp_q[0]) begin
                    failures++;
                    $display("FAIL mon_dw_payload got=%h exp=%h t=%0t",
                             {dw_addr, dw_data, dw_len}, exp_q[0], $time);
                end
                pop_pending = 1'b1;
            end else begin
                pop_pending = 1'b0;
            end
            checks++;
            if (st_ready !== (exp_q.size() < DEPTH && !fence_req)) begin
                failures++;
                $display("FAIL mon_st_ready got=%0b exp=%0b t=%0t", st_ready,
                         exp_q.size() < DEPTH && !fence_req, $time);
            end
            checks++;
            if (fence_done !== (fence_req && exp_q.size() == 0)) begin
                failures++;
                $display("FAIL mon_fence_done got=%0b exp=%0b t=%0t", fence_done,
                         fence_req && exp_q.size() == 0, $time);
            end
            checks++;
            if (ld_conflict !== conflict_m(ld_addr, ld_len)) begin
                failures++;
                $display("FAIL mon_ld_conflict got=%0b exp=%0b ld=%h/%0d t=%0t", ld_conflict,
                         conflict_m(ld_addr, ld_len), ld_addr, ld_len, $time);
            end
            checks++;
            if (err !== err_m || err_addr !== err_addr_m) begin
                failures++;
                $display("FAIL mon_err got=%0b/%h exp=%0b/%h t=%0t", err, err_addr, err_m,
                         err_addr_m, $time);
            end
        end
    end

    always @(posedge clk) begin
        if (pop_pending && !rst) begin
            void'(exp_q.pop_front());
            writes_seen++;
        end
        pop_pending = 1'b0;
    end

    // ---------------- driver ----------------
    // Called at negedge+2; drives one cycle of inputs, updates the model at the
    // edge, and returns at the following negedge+2 with the inputs still applied.
    task automatic step(input bit v, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] l, input bit fr, input bit ec,
                        input logic [31:0] la, input logic [31:0] ll);
        bit acc, ok;
        st_valid  = v;
        st_addr   = a;
        st_data   = d;
        st_len    = l;
        fence_req = fr;
        err_clr   = ec;
        ld_addr   = la;
        ld_len    = ll;
        acc = v && !fr && (exp_q.size() < DEPTH);
        ok  = legal_m(a, l);
        @(posedge clk);
        if (acc && ok) exp_q.push_back({a, d, l});
        if (acc && !ok) begin
            if (!err_m || ec) err_addr_m = a;
            err_m = 1'b1;
        end else if (ec) begin
            err_m = 1'b0;
        end
        @(negedge clk);
        #2;
    endtask

    task automatic idle(input bit fr);
        step(1'b0, 32'h0, 32'h0, 32'h0, fr, 1'b0, ld_addr, ld_len);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b1;
        fence_req = 1'b1;
        #3;
        checks++;
        if (st_ready !== 1'b0 || dw_en !== 1'b0 || fence_done !== 1'b0 || ld_conflict !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl got rdy=%0b en=%0b fd=%0b lc=%0b exp all 0",
                     st_ready, dw_en, fence_done, ld_conflict);
        end
        checks++;
        if (dw_addr !== 32'h0 || dw_data !== 32'h0 || dw_len !== 32'h0) begin
            failures++;
            $display("FAIL reset_dw got=%h/%h/%h exp=0/0/0", dw_addr, dw_data, dw_len);
        end
        checks++;
        if (err !== 1'b0 || err_addr !== 32'h0) begin
            failures++;
            $display("FAIL reset_err got=%0b/%h exp=0/0", err, err_addr);
        end
        @(negedge clk);
        #2;
        rst = 1'b0;
        fence_req = 1'b0;
    endtask

    task automatic test_single_store;
        step(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 32'd4, 1'b0, 1'b0, 32'h0, 32'd4);
        checks++;
        if (dw_en !== 1'b1 || dw_addr !== 32'h8000_0010 || dw_data !== 32'hDEAD_BEEF || dw_len !== 32'd4) begin
            failures++;
            $display("FAIL single_write got=%0b %h %h %0d exp=1 80000010 deadbeef 4",
                     dw_en, dw_addr, dw_data, dw_len);
        end
        idle(1'b0);
        checks++;
        if (dw_en !== 1'b0) begin
            failures++;
            $display("FAIL single_once got=%0b exp=0", dw_en);
        end
    endtask

    task automatic test_fence_fill;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'h8000_0040 + 4 * i, $urandom(), 32'd4, 1'b1, 1'b0, 32'h0, 32'd4);
            checks++;
            if (st_ready !== 1'b0 || dw_en !== 1'b0 || fence_done !== 1'b1) begin
                failures++;
                $display("FAIL fence_fill got rdy=%0b en=%0b fd=%0b exp 0 0 1",
                         st_ready, dw_en, fence_done);
            end
        end
    endtask

    task automatic test_fill_drain;
        logic [31:0] a;
        for (int i = 0; i < 6; i++) begin
            a = 32'h8000_0200 + 4 * i;
            step(1'b1, a, 32'h1000 + i, 32'd4, 1'b0, 1'b0, 32'h0, 32'd4);
            checks++;
            if (st_ready !== 1'b1 || dw_en !== 1'b1 || dw_addr !== a || dw_data !== 32'h1000 + i) begin
                failures++;
                $display("FAIL fill_order i=%0d got rdy=%0b en=%0b %h %h exp 1 1 %h %h",
                         i, st_ready, dw_en, dw_addr, dw_data, a, 32'h1000 + i);
            end
        end
        idle(1'b0);
    endtask

    task automatic test_rejections;
        step(1'b1, 32'h8000_0000, 32'h11, 32'd3, 1'b0, 1'b0, 32'h0, 32'd4);
        step(1'b1, 32'h8000_0002, 32'h22, 32'd4, 1'b0, 1'b0, 32'h0, 32'd4);
        checks++;
        if (dw_en !== 1'b0) begin
            failures++;
            $display("FAIL reject_nowrite got=%0b exp=0", dw_en);
        end
        step(1'b1, 32'h7FFF_FFFC, 32'h33, 32'd4, 1'b0, 1'b0, 32'h0, 32'd4);
        checks++;
        if (dw_en !== 1'b0 || err !== 1'b1 || err_addr !== 32'h8000_0000) begin
            failures++;
            $display("FAIL reject_err got en=%0b err=%0b addr=%h exp 0 1 80000000",
                     dw_en, err, err_addr);
        end
        step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 32'd4);
        checks++;
        if (err !== 1'b0 || err_addr !== 32'h8000_0000) begin
            failures++;
            $display("FAIL err_clr got err=%0b addr=%h exp 0 80000000", err, err_addr);
        end
        idle(1'b0);
    endtask

    task automatic test_load_hazard;
        logic [31:0] la [3];
        logic [31:0] ll [3];
        bit          ex [3];
        la = '{32'h8000_0103, 32'h8000_0100, 32'h8000_0100};
        ll = '{32'd1, 32'd2, 32'd4};
        ex = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h8000_0102, 32'hBEEF, 32'd2, 1'b0, 1'b0, la[i], ll[i]);
            checks++;
            if (ld_conflict !== ex[i]) begin
                failures++;
                $display("FAIL load_hazard ld=%h/%0d got=%0b exp=%0b", la[i], ll[i], ld_conflict, ex[i]);
            end
        end
        idle(1'b0);
    endtask

    task automatic test_reset_fence;
        int w0;
        step(1'b1, 32'h8000_0300, 32'hAAAA, 32'd4, 1'b0, 1'b0, 32'h8000_0300, 32'd4);
        #1;
        rst = 1'b1;
        st_valid = 1'b0;
        exp_q.delete();
        pop_pending = 1'b0;
        err_m = 1'b0;
        err_addr_m = '0;
        #1;
        checks++;
        if (dw_en !== 1'b0 || st_ready !== 1'b0 || ld_conflict !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got en=%0b rdy=%0b lc=%0b exp 0 0 0", dw_en, st_ready, ld_conflict);
        end
        @(negedge clk);
        #2;
        rst = 1'b0;
        w0 = writes_seen;
        idle(1'b0);
        idle(1'b0);
        checks++;
        if (dw_en !== 1'b0 || writes_seen != w0) begin
            failures++;
            $display("FAIL reset_discard got en=%0b writes=%0d exp 0 %0d", dw_en, writes_seen, w0);
        end
        step(1'b1, 32'h8000_0310, 32'h1, 32'd4, 1'b0, 1'b0, 32'h0, 32'd4);
        step(1'b1, 32'h8000_0314, 32'h2, 32'd4, 1'b0, 1'b0, 32'h0, 32'd4);
        checks++;
        if (fence_done !== 1'b0 || dw_addr !== 32'h8000_0314) begin
            failures++;
            $display("FAIL fence_pending got fd=%0b addr=%h exp 0 80000314", fence_done, dw_addr);
        end
        idle(1'b1);
        checks++;
        if (fence_done !== 1'b1 || st_ready !== 1'b0) begin
            failures++;
            $display("FAIL fence_done got fd=%0b rdy=%0b exp 1 0", fence_done, st_ready);
        end
        idle(1'b0);
        checks++;
        if (fence_done !== 1'b0) begin
            failures++;
            $display("FAIL fence_release got=%0b exp=0", fence_done);
        end
    endtask

    task automatic test_random;
        logic [31:0] a, l, la, ll;
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 5))
                0, 1, 2: a = 32'h8000_0100 + $urandom_range(0, 15);
                3:       a = 32'h87FF_FFF8 + $urandom_range(0, 7);
                4:       a = 32'h7FFF_FFF8 + $urandom_range(0, 7);
                default: a = $urandom();
            endcase
            case ($urandom_range(0, 7))
                0, 1:    l = 32'd1;
                2, 3:    l = 32'd2;
                4, 5:    l = 32'd4;
                6:       l = 32'd3;
                default: l = $urandom_range(0, 8);
            endcase
            if ((l == 1 || l == 2 || l == 4) && $urandom_range(0, 3) != 0) a = a & ~(l - 1);
            la = 32'h8000_0100 + $urandom_range(0, 15);
            case ($urandom_range(0, 4))
                0:       ll = 32'd1;
                1:       ll = 32'd2;
                2:       ll = 32'd4;
                3:       ll = 32'd3;
                default: ll = 32'd0;
            endcase
            step($urandom_range(0, 3) != 0, a, $urandom(), l, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 9) == 0, la, ll);
        end
        idle(1'b0);
        idle(1'b0);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_store();
        test_fence_fill();
        test_fill_drain();
        test_rejections();
        test_load_hazard();
        test_reset_fence();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
